// File: rtl/ysyx_23060184_axi_sram_pkg.sv
// Shared widths, response codes and channel FSM encodings for the AXI4-Lite SRAM responder.
package ysyx_23060184_axi_sram_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int ACERR_WIDTH = 2;
    localparam int CNT_WIDTH   = 8;

    localparam logic [ACERR_WIDTH-1:0] RESP_OKAY   = 2'b00;
    localparam logic [ACERR_WIDTH-1:0] RESP_SLVERR = 2'b10;
    localparam logic [ACERR_WIDTH-1:0] RESP_DECERR = 2'b11;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    // Countdown load for a transaction: zero means respond on the accepting edge.
    function automatic logic [CNT_WIDTH-1:0] lat_load(input int lat, input logic [1:0] jitter);
        return CNT_WIDTH'(lat - 1) + CNT_WIDTH'(jitter);
    endfunction

endpackage

// File: rtl/ysyx_23060184_axi_sram_lfsr8.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, with synchronous seed load and step enable.
module ysyx_23060184_lfsr8 (
    input  logic       clk,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       step,
    output logic [1:0] q_lo
);

    logic [7:0] q;
    logic       fb;

    assign fb   = q[7] ^ q[5] ^ q[4] ^ q[3];
    assign q_lo = q[1:0];

    always_ff @(posedge clk) begin
        if (load) begin
            q <= seed;
        end else if (step) begin
            q <= {q[6:0], fb};
        end
    end

endmodule

// File: rtl/ysyx_23060184_axi_sram.sv
// AXI4-Lite responder over a word-addressed SRAM: independent read/write channels with
// programmable response latency and optional LFSR jitter.
module ysyx_23060184_axi_sram
    import ysyx_23060184_axi_sram_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          RD_LAT      = 1,
    parameter int          WR_LAT      = 1,
    parameter bit          RAND_LAT    = 1'b0
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [DATA_WIDTH-1:0]   araddr,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [ACERR_WIDTH-1:0]  rresp,
    output logic                    rvalid,
    input  logic                    rready,
    input  logic [DATA_WIDTH-1:0]   awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ACERR_WIDTH-1:0]  bresp,
    output logic                    bvalid,
    input  logic                    bready
);

    localparam int          IDX_WIDTH = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] LIMIT     = 33'(DEPTH_WORDS) << 2;

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    logic [1:0] lfsr_lo;
    logic [1:0] jitter;
    logic       ar_fire;
    logic       wr_pair;

    r_state_t              r_state, r_state_n;
    logic [CNT_WIDTH-1:0]  r_cnt, r_cnt_n;
    logic [DATA_WIDTH-1:0] ar_addr_q, ar_addr_n;
    logic [DATA_WIDTH-1:0] rdata_n;
    logic [ACERR_WIDTH-1:0] rresp_n;
    logic                  rvalid_n;
    logic                  rd_sample;
    logic [DATA_WIDTH-1:0] rd_off;
    logic                  rd_ok;
    logic [IDX_WIDTH-1:0]  rd_idx;

    w_state_t              w_state, w_state_n;
    logic [CNT_WIDTH-1:0]  w_cnt, w_cnt_n;
    logic                  have_aw, have_aw_n;
    logic                  have_w, have_w_n;
    logic [DATA_WIDTH-1:0] aw_addr_q, aw_addr_n;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_n;
    logic [DATA_WIDTH/8-1:0] w_strb_q, w_strb_n;
    logic [ACERR_WIDTH-1:0] bresp_n;
    logic                  bvalid_n;
    logic                  wr_commit;
    logic [DATA_WIDTH-1:0] wr_off;
    logic                  wr_ok;
    logic [IDX_WIDTH-1:0]  wr_idx;

    // A same-cycle AR and write pair share one jitter value and one LFSR step.
    ysyx_23060184_lfsr8 u_lfsr (
        .clk  (clk),
        .load (!resetn),
        .seed (LFSR_SEED),
        .step (ar_fire || wr_pair),
        .q_lo (lfsr_lo)
    );

    assign jitter  = lfsr_lo & {2{RAND_LAT}};
    assign arready = (r_state == R_IDLE);
    assign awready = (w_state == W_IDLE) && !have_aw;
    assign wready  = (w_state == W_IDLE) && !have_w;
    assign ar_fire = arvalid && arready;

    assign rd_off = ar_addr_n - ADDR_BASE;
    assign rd_ok  = (ar_addr_n >= ADDR_BASE) && ({1'b0, rd_off} < LIMIT);
    assign rd_idx = IDX_WIDTH'(rd_off >> 2);

    assign wr_off = aw_addr_n - ADDR_BASE;
    assign wr_ok  = (aw_addr_n >= ADDR_BASE) && ({1'b0, wr_off} < LIMIT);
    assign wr_idx = IDX_WIDTH'(wr_off >> 2);

    always_comb begin
        r_state_n = r_state;
        r_cnt_n   = r_cnt;
        ar_addr_n = ar_addr_q;
        rdata_n   = rdata;
        rresp_n   = rresp;
        rvalid_n  = rvalid;
        rd_sample = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (ar_fire) begin
                    ar_addr_n = araddr;
                    r_cnt_n   = lat_load(RD_LAT, jitter);
                    if (r_cnt_n == '0) begin
                        rd_sample = 1'b1;
                    end else begin
                        r_state_n = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (r_cnt == CNT_WIDTH'(1)) begin
                    rd_sample = 1'b1;
                end else begin
                    r_cnt_n = r_cnt - 1'b1;
                end
            end
            R_RESP: begin
                if (rready) begin
                    rvalid_n  = 1'b0;
                    r_state_n = R_IDLE;
                end
            end
            default: r_state_n = R_IDLE;
        endcase
        if (rd_sample) begin
            rdata_n   = rd_ok ? mem[rd_idx] : '0;
            rresp_n   = rd_ok ? RESP_OKAY : RESP_DECERR;
            rvalid_n  = 1'b1;
            r_cnt_n   = '0;
            r_state_n = R_RESP;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= R_IDLE;
            r_cnt     <= '0;
            ar_addr_q <= '0;
            rdata     <= '0;
            rresp     <= RESP_OKAY;
            rvalid    <= 1'b0;
        end else begin
            r_state   <= r_state_n;
            r_cnt     <= r_cnt_n;
            ar_addr_q <= ar_addr_n;
            rdata     <= rdata_n;
            rresp     <= rresp_n;
            rvalid    <= rvalid_n;
        end
    end

    // AW and W latch independently; the countdown starts on the edge both are held.
    always_comb begin
        w_state_n = w_state;
        w_cnt_n   = w_cnt;
        have_aw_n = have_aw;
        have_w_n  = have_w;
        aw_addr_n = aw_addr_q;
        w_data_n  = w_data_q;
        w_strb_n  = w_strb_q;
        bresp_n   = bresp;
        bvalid_n  = bvalid;
        wr_commit = 1'b0;
        wr_pair   = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (awvalid && awready) begin
                    have_aw_n = 1'b1;
                    aw_addr_n = awaddr;
                end
                if (wvalid && wready) begin
                    have_w_n = 1'b1;
                    w_data_n = wdata;
                    w_strb_n = wstrb;
                end
                if (have_aw_n && have_w_n) begin
                    wr_pair = 1'b1;
                    w_cnt_n = lat_load(WR_LAT, jitter);
                    if (w_cnt_n == '0) begin
                        wr_commit = 1'b1;
                    end else begin
                        w_state_n = W_WAIT;
                    end
                end
            end
            W_WAIT: begin
                if (w_cnt == CNT_WIDTH'(1)) begin
                    wr_commit = 1'b1;
                end else begin
                    w_cnt_n = w_cnt - 1'b1;
                end
            end
            W_RESP: begin
                if (bready) begin
                    bvalid_n  = 1'b0;
                    have_aw_n = 1'b0;
                    have_w_n  = 1'b0;
                    w_state_n = W_IDLE;
                end
            end
            default: w_state_n = W_IDLE;
        endcase
        if (wr_commit) begin
            bresp_n   = wr_ok ? RESP_OKAY : RESP_DECERR;
            bvalid_n  = 1'b1;
            w_cnt_n   = '0;
            w_state_n = W_RESP;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            w_state   <= W_IDLE;
            w_cnt     <= '0;
            have_aw   <= 1'b0;
            have_w    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp     <= RESP_OKAY;
            bvalid    <= 1'b0;
        end else begin
            w_state   <= w_state_n;
            w_cnt     <= w_cnt_n;
            have_aw   <= have_aw_n;
            have_w    <= have_w_n;
            aw_addr_q <= aw_addr_n;
            w_data_q  <= w_data_n;
            w_strb_q  <= w_strb_n;
            bresp     <= bresp_n;
            bvalid    <= bvalid_n;
        end
    end

    // Contents survive reset; a reset landing on the commit edge cancels the write.
    always_ff @(posedge clk) begin
        if (resetn && wr_commit && wr_ok) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (w_strb_n[b]) begin
                    mem[wr_idx][8*b +: 8] <= w_data_n[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060184_axi_sram.sv
// Directed and scoreboard checks for the AXI4-Lite SRAM responder: a fixed-latency
// instance (RD_LAT=3) and a jittered instance (RAND_LAT=1, DEPTH_WORDS=16).
module tb_ysyx_23060184_axi_sram;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic        m_resetn, m_arvalid, m_arready, m_rvalid, m_rready;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_rresp, m_bresp;

    logic        j_resetn, j_arvalid, j_arready, j_rvalid, j_rready;
    logic        j_awvalid, j_awready, j_wvalid, j_wready, j_bvalid, j_bready;
    logic [31:0] j_araddr, j_rdata, j_awaddr, j_wdata;
    logic [3:0]  j_wstrb;
    logic [1:0]  j_rresp, j_bresp;

    ysyx_23060184_axi_sram #(.RD_LAT(3), .WR_LAT(1), .RAND_LAT(1'b0)) u_dut (
        .clk(clk), .resetn(m_resetn),
        .araddr(m_araddr), .arvalid(m_arvalid), .arready(m_arready),
        .rdata(m_rdata), .rresp(m_rresp), .rvalid(m_rvalid), .rready(m_rready),
        .awaddr(m_awaddr), .awvalid(m_awvalid), .awready(m_awready),
        .wdata(m_wdata), .wstrb(m_wstrb), .wvalid(m_wvalid), .wready(m_wready),
        .bresp(m_bresp), .bvalid(m_bvalid), .bready(m_bready)
    );

    ysyx_23060184_axi_sram #(.DEPTH_WORDS(16), .RD_LAT(1), .WR_LAT(1), .RAND_LAT(1'b1)) u_jit (
        .clk(clk), .resetn(j_resetn),
        .araddr(j_araddr), .arvalid(j_arvalid), .arready(j_arready),
        .rdata(j_rdata), .rresp(j_rresp), .rvalid(j_rvalid), .rready(j_rready),
        .awaddr(j_awaddr), .awvalid(j_awvalid), .awready(j_awready),
        .wdata(j_wdata), .wstrb(j_wstrb), .wvalid(j_wvalid), .wready(j_wready),
        .bresp(j_bresp), .bvalid(j_bvalid), .bready(j_bready)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output int lat);
        m_awaddr = a; m_wdata = d; m_wstrb = s;
        m_awvalid = 1'b1; m_wvalid = 1'b1; m_bready = 1'b1;
        tick();
        m_awvalid = 1'b0; m_wvalid = 1'b0; lat = 1;
        while (!m_bvalid && lat < 40) begin tick(); lat++; end
        resp = m_bresp;
        tick();
    endtask

    task automatic m_read(input logic [31:0] a, output logic [31:0] d,
                          output logic [1:0] resp, output int lat);
        m_araddr = a; m_arvalid = 1'b1; m_rready = 1'b1;
        tick();
        m_arvalid = 1'b0; lat = 1;
        while (!m_rvalid && lat < 40) begin tick(); lat++; end
        d = m_rdata; resp = m_rresp;
        tick();
    endtask

    task automatic j_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int gap, output logic [1:0] resp, output int lat);
        j_awaddr = a; j_wdata = d; j_wstrb = s; j_wvalid = 1'b1; j_bready = 1'b1;
        repeat (gap) begin tick(); j_wvalid = 1'b0; end
        j_awvalid = 1'b1;
        tick();
        j_awvalid = 1'b0; j_wvalid = 1'b0; lat = 1;
        while (!j_bvalid && lat < 40) begin tick(); lat++; end
        resp = j_bresp;
        tick();
    endtask

    task automatic j_read(input logic [31:0] a, input int dly, output logic [31:0] d,
                          output logic [1:0] resp, output int lat);
        j_araddr = a; j_arvalid = 1'b1; j_rready = 1'b0;
        tick();
        j_arvalid = 1'b0; lat = 1;
        while (!j_rvalid && lat < 40) begin tick(); lat++; end
        repeat (dly) tick();
        d = j_rdata; resp = j_rresp;
        j_rready = 1'b1;
        tick();
        j_rready = 1'b0;
    endtask

    task automatic test_reset;
        m_resetn = 1'b0; j_resetn = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({m_arready, m_awready, m_wready, m_rvalid, m_bvalid} !== 5'b11100) begin
            n_bad++;
            $display("FAIL reset_hs: got %b want 11100",
                     {m_arready, m_awready, m_wready, m_rvalid, m_bvalid});
        end
        n_cmp++;
        if (m_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", m_rdata); end
        n_cmp++;
        if ({m_rresp, m_bresp} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_resp: got %b want 0000", {m_rresp, m_bresp});
        end
        m_resetn = 1'b1; j_resetn = 1'b1;
        tick();
    endtask

    task automatic test_write_read;
        logic [1:0] resp; logic [31:0] d; int lat;
        m_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, resp, lat);
        n_cmp++;
        if ({resp, lat[5:0]} !== {2'b00, 6'd1}) begin
            n_bad++; $display("FAIL wr_basic: got resp=%b lat=%0d want resp=00 lat=1", resp, lat);
        end
        m_read(32'h8000_0010, d, resp, lat);
        n_cmp++;
        if ({d, resp} !== {32'hDEAD_BEEF, 2'b00}) begin
            n_bad++; $display("FAIL rd_basic: got %h/%b want deadbeef/00", d, resp);
        end
        n_cmp++;
        if (lat !== 3) begin n_bad++; $display("FAIL rd_basic_lat: got %0d want 3", lat); end
    endtask

    task automatic test_w_before_aw;
        logic [1:0] resp; logic [31:0] d; int lat;
        m_wdata = 32'h1122_3344; m_wstrb = 4'b0101; m_wvalid = 1'b1; m_bready = 1'b0;
        m_awaddr = 32'h8000_0010;
        tick();
        m_wvalid = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({m_awready, m_wready, m_bvalid} !== 3'b100) begin
            n_bad++; $display("FAIL w_first_hold: got %b want 100", {m_awready, m_wready, m_bvalid});
        end
        m_awvalid = 1'b1;
        tick();
        m_awvalid = 1'b0;
        n_cmp++;
        if ({m_awready, m_wready, m_bvalid, m_bresp} !== 5'b00100) begin
            n_bad++; $display("FAIL w_first_resp: got %b want 00100",
                              {m_awready, m_wready, m_bvalid, m_bresp});
        end
        tick();
        n_cmp++;
        if ({m_awready, m_wready, m_bvalid} !== 3'b001) begin
            n_bad++; $display("FAIL w_first_bhold: got %b want 001", {m_awready, m_wready, m_bvalid});
        end
        m_bready = 1'b1;
        tick();
        n_cmp++;
        if ({m_awready, m_wready, m_bvalid} !== 3'b110) begin
            n_bad++; $display("FAIL w_first_done: got %b want 110", {m_awready, m_wready, m_bvalid});
        end
        m_read(32'h8000_0010, d, resp, lat);
        n_cmp++;
        if (d !== 32'hDE22_BE44) begin n_bad++; $display("FAIL strb_merge: got %h want de22be44", d); end
    endtask

    task automatic test_decode;
        logic [1:0] resp; logic [31:0] d; int lat;
        m_write(32'h8000_0000, 32'hCAFE_F00D, 4'hF, resp, lat);
        m_write(32'h8000_3FFD, 32'h1234_5678, 4'hF, resp, lat);
        n_cmp++;
        if (resp !== 2'b00) begin n_bad++; $display("FAIL dec_last_ok: got %b want 00", resp); end
        m_read(32'h7FFF_FFFC, d, resp, lat);
        n_cmp++;
        if ({d, resp} !== {32'h0, 2'b11}) begin
            n_bad++; $display("FAIL dec_rd_low: got %h/%b want 0/11", d, resp);
        end
        m_read(32'h8000_4000, d, resp, lat);
        n_cmp++;
        if ({d, resp} !== {32'h0, 2'b11}) begin
            n_bad++; $display("FAIL dec_rd_high: got %h/%b want 0/11", d, resp);
        end
        m_write(32'h7FFF_FFFC, 32'hBAD0_0001, 4'hF, resp, lat);
        n_cmp++;
        if (resp !== 2'b11) begin n_bad++; $display("FAIL dec_wr_low: got %b want 11", resp); end
        m_write(32'h8000_4000, 32'hBAD0_0002, 4'hF, resp, lat);
        n_cmp++;
        if (resp !== 2'b11) begin n_bad++; $display("FAIL dec_wr_high: got %b want 11", resp); end
        m_read(32'h8000_0000, d, resp, lat);
        n_cmp++;
        if (d !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL dec_word0: got %h want cafef00d", d); end
        m_read(32'h8000_3FFC, d, resp, lat);
        n_cmp++;
        if ({d, resp} !== {32'h1234_5678, 2'b00}) begin
            n_bad++; $display("FAIL dec_lastword: got %h/%b want 12345678/00", d, resp);
        end
    endtask

    task automatic test_rd_latency;
        int n;
        m_araddr = 32'h8000_0010; m_arvalid = 1'b1; m_rready = 1'b0;
        tick();
        m_arvalid = 1'b0; n = 1;
        n_cmp++;
        if (m_arready !== 1'b0) begin n_bad++; $display("FAIL lat_arready: got %b want 0", m_arready); end
        while (!m_rvalid && n < 20) begin tick(); n++; end
        n_cmp++;
        if (n !== 3) begin n_bad++; $display("FAIL lat_rvalid: got %0d want 3", n); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({m_rvalid, m_arready, m_rresp, m_rdata} !== {1'b1, 1'b0, 2'b00, 32'hDE22_BE44}) begin
                n_bad++; $display("FAIL lat_hold%0d: got %b/%b/%h want 1/0/de22be44",
                                  i, m_rvalid, m_arready, m_rdata);
            end
            tick();
        end
        m_rready = 1'b1;
        tick();
        n_cmp++;
        if ({m_rvalid, m_arready} !== 2'b01) begin
            n_bad++; $display("FAIL lat_release: got %b want 01", {m_rvalid, m_arready});
        end
    endtask

    task automatic test_same_cycle;
        logic [1:0] resp; logic [31:0] d; int lat;
        m_write(32'h8000_0020, 32'h0, 4'hF, resp, lat);
        m_araddr = 32'h8000_0020; m_arvalid = 1'b1; m_rready = 1'b1;
        tick();
        m_arvalid = 1'b0;
        tick();
        m_awaddr = 32'h8000_0020; m_wdata = 32'h5; m_wstrb = 4'hF;
        m_awvalid = 1'b1; m_wvalid = 1'b1; m_bready = 1'b1;
        tick();
        m_awvalid = 1'b0; m_wvalid = 1'b0;
        n_cmp++;
        if ({m_rvalid, m_bvalid, m_rdata} !== {1'b1, 1'b1, 32'h0}) begin
            n_bad++; $display("FAIL same_cycle_old: got rv=%b bv=%b rdata=%h want 1/1/0",
                              m_rvalid, m_bvalid, m_rdata);
        end
        tick();
        m_read(32'h8000_0020, d, resp, lat);
        n_cmp++;
        if (d !== 32'h5) begin n_bad++; $display("FAIL same_cycle_new: got %h want 5", d); end
    endtask

    task automatic test_jitter_lfsr;
        logic [1:0] resp; logic [31:0] d; int lat;
        j_resetn = 1'b0; tick(); j_resetn = 1'b1;
        j_read(BASE, 0, d, resp, lat);
        n_cmp++;
        if (lat !== 2) begin n_bad++; $display("FAIL jit_rd0: got %0d want 2", lat); end
        j_read(BASE, 0, d, resp, lat);
        n_cmp++;
        if (lat !== 3) begin n_bad++; $display("FAIL jit_rd1: got %0d want 3", lat); end
        j_read(BASE, 0, d, resp, lat);
        n_cmp++;
        if (lat !== 2) begin n_bad++; $display("FAIL jit_rd2: got %0d want 2", lat); end
        j_write(BASE, 32'h0, 4'hF, 0, resp, lat);
        n_cmp++;
        if (lat !== 3) begin n_bad++; $display("FAIL jit_wr3: got %0d want 3", lat); end
    endtask

    task automatic test_reset_midflight;
        logic [1:0] resp; logic [31:0] d; int lat;
        j_write(BASE + 32'd12, 32'h0A0A_0A0A, 4'hF, 0, resp, lat);
        j_resetn = 1'b0; tick(); j_resetn = 1'b1;
        j_araddr = BASE + 32'd12; j_arvalid = 1'b1; j_rready = 1'b0;
        j_awaddr = BASE + 32'd12; j_wdata = 32'hFFFF_FFFF; j_wstrb = 4'hF;
        j_awvalid = 1'b1; j_wvalid = 1'b1; j_bready = 1'b0;
        tick();
        j_arvalid = 1'b0; j_awvalid = 1'b0; j_wvalid = 1'b0;
        n_cmp++;
        if ({j_arready, j_awready, j_wready, j_rvalid, j_bvalid} !== 5'b00000) begin
            n_bad++; $display("FAIL mid_waiting: got %b want 00000",
                              {j_arready, j_awready, j_wready, j_rvalid, j_bvalid});
        end
        j_resetn = 1'b0;
        tick();
        n_cmp++;
        if ({j_arready, j_awready, j_wready, j_rvalid, j_bvalid} !== 5'b11100) begin
            n_bad++; $display("FAIL mid_reset: got %b want 11100",
                              {j_arready, j_awready, j_wready, j_rvalid, j_bvalid});
        end
        j_resetn = 1'b1;
        j_read(BASE + 32'd12, 0, d, resp, lat);
        n_cmp++;
        if (d !== 32'h0A0A_0A0A) begin n_bad++; $display("FAIL mid_nocommit: got %h want 0a0a0a0a", d); end
    endtask

    task automatic test_random;
        logic [31:0] sb [16];
        logic [1:0]  resp, exp_resp;
        logic [31:0] d, a, wd, exp_d;
        logic [3:0]  s;
        int idx, lat;
        for (int i = 0; i < 16; i++) begin
            sb[i] = $urandom;
            j_write(BASE + 32'(4 * i), sb[i], 4'hF, 0, resp, lat);
        end
        for (int t = 0; t < 200; t++) begin
            idx = $urandom_range(0, 17);
            a = BASE + 32'(4 * idx) + 32'($urandom_range(0, 3));
            exp_resp = (idx < 16) ? 2'b00 : 2'b11;
            if ($urandom_range(0, 1) == 1) begin
                wd = $urandom; s = 4'($urandom_range(0, 15));
                j_write(a, wd, s, $urandom_range(0, 2), resp, lat);
                if (idx < 16) begin
                    for (int b = 0; b < 4; b++) if (s[b]) sb[idx][8*b +: 8] = wd[8*b +: 8];
                end
                n_cmp++;
                if (resp !== exp_resp || lat >= 40) begin
                    n_bad++; $display("FAIL rnd_wr%0d: got resp=%b lat=%0d want resp=%b", t, resp, lat, exp_resp);
                end
            end else begin
                j_read(a, $urandom_range(0, 2), d, resp, lat);
                exp_d = (idx < 16) ? sb[idx] : 32'h0;
                n_cmp++;
                if ({d, resp} !== {exp_d, exp_resp} || lat >= 40) begin
                    n_bad++; $display("FAIL rnd_rd%0d: got %h/%b lat=%0d want %h/%b",
                                      t, d, resp, lat, exp_d, exp_resp);
                end
            end
        end
    endtask

    initial begin
        {m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready} = '0;
        {j_arvalid, j_rready, j_awvalid, j_wvalid, j_bready} = '0;
        {m_araddr, m_awaddr, m_wdata, m_wstrb} = '0;
        {j_araddr, j_awaddr, j_wdata, j_wstrb} = '0;
        m_resetn = 1'b0; j_resetn = 1'b0;
        test_reset();
        test_write_read();
        test_w_before_aw();
        test_decode();
        test_rd_latency();
        test_same_cycle();
        test_jitter_lfsr();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
